// File: rtl/riscV_unrn_pkg.sv
// Shared types and constants for the M-mode trap controller.
package riscV_unrn_pkg;

  localparam int XLEN = 32;

  // Trap vector base; the low two bits are treated as zero by the controller.
  localparam logic [31:0] HARDCODED_MTVEC = 32'h8000_0004;

  localparam logic [1:0] MPP_MACHINE         = 2'b11;
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // mcause encodings
  localparam logic [31:0] M_ILL_INSTR = 32'd2;
  localparam logic [31:0] M_BREAKPOINT = 32'd3;
  localparam logic [31:0] M_ECALL     = 32'd11;
  localparam logic [31:0] M_EXT_INT   = 32'h8000_000B;
  localparam logic [31:0] M_TIMER_INT = 32'h8000_0007;

  // Only MEI (bit 11) and MTI (bit 7) can raise a trap here.
  localparam logic [31:0] SUPPORTED_INTERRUPTS_MASK = 32'h0000_0880;

  typedef enum logic [2:0] {IDLE, SAVE, STACK, UNSTACK, REDIR} trap_state_t;

  typedef struct packed {
    logic [18:0] rsvd_hi;   // [31:13]
    logic [1:0]  mpp;       // [12:11]
    logic [2:0]  rsvd_mid;  // [10:8]
    logic        mpie;      // [7]
    logic [2:0]  rsvd_lo1;  // [6:4]
    logic        mie;       // [3]
    logic [2:0]  rsvd_lo0;  // [2:0]
  } mstatus_csr_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;   // [31:12]
    logic        mei;       // [11]
    logic [2:0]  rsvd_mid;  // [10:8]
    logic        mti;       // [7]
    logic [6:0]  rsvd_lo;   // [6:0]
  } irq_csr_t;

  typedef irq_csr_t mie_csr_t;
  typedef irq_csr_t mip_csr_t;

  // Trap entry: remember the old interrupt enable and disable interrupts.
  function automatic mstatus_csr_t mstatus_stack(input mstatus_csr_t s);
    mstatus_csr_t r;
    r      = s;
    r.mpie = s.mie;
    r.mie  = 1'b0;
    r.mpp  = MPP_MACHINE;
    return r;
  endfunction

  // Trap return: restore the interrupt enable saved on entry.
  function automatic mstatus_csr_t mstatus_unstack(input mstatus_csr_t s);
    mstatus_csr_t r;
    r      = s;
    r.mie  = s.mpie;
    r.mpie = 1'b1;
    r.mpp  = MPP_MACHINE;
    return r;
  endfunction

endpackage

// File: rtl/riscv_irq_prio.sv
// Interrupt pending/priority resolver: MEI wins over MTI.
module riscv_irq_prio
  import riscV_unrn_pkg::*;
(
  input  logic        mstatus_mie,
  input  mie_csr_t    mie,
  input  mip_csr_t    mip,
  output logic        irq_valid,
  output logic [31:0] irq_cause
);

  logic [31:0] pending;

  // Enabled-and-pending supported interrupts, gated by the global enable.
  always_comb begin
    pending   = mie & mip & SUPPORTED_INTERRUPTS_MASK;
    irq_valid = mstatus_mie & (|pending);
    irq_cause = pending[11] ? M_EXT_INT : M_TIMER_INT;
  end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// M-mode trap/MRET sequencer: CSR save, mstatus stack/unstack, PC redirect.
// Optional build macro VECTORED_MTVEC_EN: interrupts redirect to
// base + 4*cause; otherwise every trap goes to the base (direct mode).
module riscv_trap_ctrl
  import riscV_unrn_pkg::*;
#(
  parameter logic [XLEN-1:0] MTVEC_BASE = HARDCODED_MTVEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exc_valid_i,
  input  logic [31:0]      exc_cause_i,
  input  logic [XLEN-1:0]  exc_epc_i,
  input  logic [XLEN-1:0]  exc_tval_i,
  input  logic             boundary_i,
  input  logic [XLEN-1:0]  int_epc_i,
  input  logic             mret_i,
  input  mstatus_csr_t     mstatus_i,
  input  mie_csr_t         mie_i,
  input  mip_csr_t         mip_i,
  input  logic [XLEN-1:0]  mepc_i,
  output logic             flush_o,
  output logic             busy_o,
  output logic             mepc_we_o,
  output logic [XLEN-1:0]  mepc_wdata_o,
  output logic             mcause_we_o,
  output logic [31:0]      mcause_wdata_o,
  output logic             mtval_we_o,
  output logic [XLEN-1:0]  mtval_wdata_o,
  output logic             mstatus_we_o,
  output mstatus_csr_t     mstatus_wdata_o,
  output logic             redir_valid_o,
  output logic [XLEN-1:0]  redir_pc_o,
  input  logic             redir_ready_i
);

  localparam logic [XLEN-1:0] ALIGN_MASK    = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MTVEC_ALIGNED = MTVEC_BASE & ALIGN_MASK;

  trap_state_t     state_reg;
  logic            irq_valid;
  logic [31:0]     irq_cause;
  logic            take_irq;
  logic [XLEN-1:0] irq_target;

  riscv_irq_prio u_irq_prio (
    .mstatus_mie (mstatus_i.mie),
    .mie         (mie_i),
    .mip         (mip_i),
    .irq_valid   (irq_valid),
    .irq_cause   (irq_cause)
  );

  assign take_irq = irq_valid & boundary_i;

`ifdef VECTORED_MTVEC_EN
  assign irq_target = MTVEC_ALIGNED + (irq_cause << 2);
`else
  assign irq_target = MTVEC_ALIGNED;
`endif

  // Acceptance is only possible from IDLE; everything is ignored while busy.
  assign flush_o = (state_reg == IDLE) & (exc_valid_i | take_irq | mret_i);

  // Sequencer with registered CSR-write and redirect outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      busy_o          <= 1'b0;
      mepc_we_o       <= 1'b0;
      mepc_wdata_o    <= '0;
      mcause_we_o     <= 1'b0;
      mcause_wdata_o  <= '0;
      mtval_we_o      <= 1'b0;
      mtval_wdata_o   <= '0;
      mstatus_we_o    <= 1'b0;
      mstatus_wdata_o <= '0;
      redir_valid_o   <= 1'b0;
      redir_pc_o      <= '0;
    end else begin
      mepc_we_o    <= 1'b0;
      mcause_we_o  <= 1'b0;
      mtval_we_o   <= 1'b0;
      mstatus_we_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (exc_valid_i) begin
            state_reg      <= SAVE;
            busy_o         <= 1'b1;
            mepc_we_o      <= 1'b1;
            mcause_we_o    <= 1'b1;
            mtval_we_o     <= 1'b1;
            mepc_wdata_o   <= exc_epc_i & ALIGN_MASK;
            mcause_wdata_o <= exc_cause_i;
            mtval_wdata_o  <= exc_tval_i;
            redir_pc_o     <= MTVEC_ALIGNED;
          end else if (take_irq) begin
            state_reg      <= SAVE;
            busy_o         <= 1'b1;
            mepc_we_o      <= 1'b1;
            mcause_we_o    <= 1'b1;
            mtval_we_o     <= 1'b1;
            mepc_wdata_o   <= int_epc_i & ALIGN_MASK;
            mcause_wdata_o <= irq_cause;
            mtval_wdata_o  <= '0;
            redir_pc_o     <= irq_target;
          end else if (mret_i) begin
            state_reg       <= UNSTACK;
            busy_o          <= 1'b1;
            mstatus_we_o    <= 1'b1;
            mstatus_wdata_o <= mstatus_unstack(mstatus_i);
          end
        end
        SAVE: begin
          state_reg       <= STACK;
          mstatus_we_o    <= 1'b1;
          mstatus_wdata_o <= mstatus_stack(mstatus_i);
        end
        STACK: begin
          state_reg     <= REDIR;
          redir_valid_o <= 1'b1;
        end
        UNSTACK: begin
          state_reg     <= REDIR;
          redir_valid_o <= 1'b1;
          redir_pc_o    <= mepc_i;
        end
        REDIR: begin
          if (redir_ready_i) begin
            state_reg     <= IDLE;
            busy_o        <= 1'b0;
            redir_valid_o <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          busy_o        <= 1'b0;
          redir_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
